// File: rtl/cskip_serial_subtractor_pkg.sv
// cskip_serial_subtractor_pkg: shared state encoding and sizing helpers for the serial carry-skip subtractor
package cskip_serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction
  // one extra count past the last group marks the commit cycle
  function automatic int blk_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/cskip_serial_subtractor_if.sv
// cskip_serial_subtractor_if: operand/result ready-valid bundle for the serial subtractor
interface cskip_serial_subtractor_if #(parameter int WIDTH = 12, parameter int BLOCK = 4);
  import cskip_serial_subtractor_pkg::*;
  localparam int NBLK = nblk(WIDTH, BLOCK);
  logic [WIDTH-1:0] i_minuend;
  logic [WIDTH-1:0] i_subtrahend;
  logic i_valid;
  logic o_ready;
  logic [WIDTH-1:0] o_diff;
  logic o_borrow;
  logic [NBLK-1:0] o_skip_mask;
  logic o_valid;
  logic i_ready;
  modport master (
    output i_minuend, i_subtrahend, i_valid, i_ready,
    input o_ready, o_diff, o_borrow, o_skip_mask, o_valid
  );
  modport slave (
    input i_minuend, i_subtrahend, i_valid, i_ready,
    output o_ready, o_diff, o_borrow, o_skip_mask, o_valid
  );
endinterface

// File: rtl/cskip_serial_subtractor_group.sv
// cskip_serial_subtractor_group: one BLOCK-bit carry-skip group, ripple carry with a propagate bypass mux
module cskip_serial_subtractor_group #(parameter int BLOCK = 4) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] nb,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             p
);
  logic [BLOCK-1:0] gv;
  logic [BLOCK-1:0] pv;
  logic rc;
  assign gv = a & nb;
  assign pv = a ^ nb;
  always_comb begin
    rc = cin;
    sum = '0;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i] = pv[i] ^ rc;
      rc = gv[i] | (pv[i] & rc);
    end
  end
  assign p = &pv;
  assign cout = p ? cin : rc;
endmodule

// File: rtl/cskip_serial_subtractor.sv
// cskip_serial_subtractor: block-serial A - B (A + ~B + 1), one carry-skip group per RUN cycle
module cskip_serial_subtractor
  import cskip_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int BLOCK = 4
) (
  input logic i_clk,
  input logic i_rst,
  cskip_serial_subtractor_if.slave bus
);
  localparam int NBLK = nblk(WIDTH, BLOCK);
  localparam int BW = blk_w(NBLK);
  if (WIDTH % BLOCK != 0 || WIDTH < BLOCK) begin : g_bad_width
    $error("WIDTH must be a non-zero multiple of BLOCK");
  end
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, nb_q, diff_acc, diff_q;
  logic [NBLK-1:0] mask_acc, mask_q;
  logic [BW-1:0] blk_q;
  logic carry_q, borrow_q, last;
  logic [BLOCK-1:0] g_sum;
  logic g_cout, g_p;
  cskip_serial_subtractor_group #(.BLOCK(BLOCK)) u_grp (
    .a(a_q[BLOCK-1:0]),
    .nb(nb_q[BLOCK-1:0]),
    .cin(carry_q),
    .sum(g_sum),
    .cout(g_cout),
    .p(g_p)
  );
  // all groups consumed; this RUN cycle commits the accumulators to the outputs
  assign last = blk_q == BW'(NBLK);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = bus.i_valid ? RUN : IDLE;
      RUN: state_d = last ? DONE : RUN;
      DONE: state_d = bus.i_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q <= '0;
      nb_q <= '0;
      carry_q <= 1'b0;
      blk_q <= '0;
      diff_acc <= '0;
      mask_acc <= '0;
      diff_q <= '0;
      mask_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.i_valid) begin
        a_q <= bus.i_minuend;
        nb_q <= ~bus.i_subtrahend;
        carry_q <= 1'b1;
        blk_q <= '0;
        diff_acc <= '0;
        mask_acc <= '0;
      end else if (state_q == RUN && last) begin
        diff_q <= diff_acc;
        mask_q <= mask_acc;
        borrow_q <= ~carry_q;
      end else if (state_q == RUN) begin
        a_q <= a_q >> BLOCK;
        nb_q <= nb_q >> BLOCK;
        carry_q <= g_cout;
        blk_q <= blk_q + BW'(1);
        diff_acc[blk_q*BLOCK +: BLOCK] <= g_sum;
        mask_acc[blk_q] <= g_p;
      end
    end
  end
  assign bus.o_ready = state_q == IDLE;
  assign bus.o_valid = state_q == DONE;
  assign bus.o_diff = diff_q;
  assign bus.o_borrow = borrow_q;
  assign bus.o_skip_mask = mask_q;
endmodule

// File: tb/tb_cskip_serial_subtractor.sv
// tb_cskip_serial_subtractor: directed vectors with hand-computed differences, borrows and skip masks
module tb_cskip_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  int lat;
  always #5 clk = ~clk;
  cskip_serial_subtractor_if #(.WIDTH(12), .BLOCK(4)) bus ();
  cskip_serial_subtractor #(.WIDTH(12), .BLOCK(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  logic [11:0] va [10] = '{12'h000, 12'h001, 12'h800, 12'hFFF, 12'h123, 12'h000, 12'hFFF, 12'h5A5, 12'h0F0, 12'h3C7};
  logic [11:0] vb [10] = '{12'h000, 12'h002, 12'h001, 12'hFFF, 12'h123, 12'h001, 12'h000, 12'h0F0, 12'h5A5, 12'h2C7};
  logic [11:0] vd [10] = '{12'h000, 12'hFFF, 12'h7FF, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'h4B5, 12'hB4B, 12'h100};
  logic vbo [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [2:0] vm [10] = '{3'b111, 3'b110, 3'b010, 3'b111, 3'b111, 3'b110, 3'b000, 3'b000, 3'b000, 3'b011};
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [11:0] a, input logic [11:0] b, input bit noise, output int l);
    int t;
    bus.i_minuend = a;
    bus.i_subtrahend = b;
    bus.i_valid = 1'b1;
    t = 0;
    while (!bus.o_ready && t < 20) begin
      tick();
      t++;
    end
    chk("ready_before_accept", 12'(bus.o_ready), 12'd1);
    tick();
    bus.i_valid = noise;
    bus.i_minuend = ~a;
    bus.i_subtrahend = a ^ b;
    l = 0;
    while (!bus.o_valid && l < 20) begin
      if (noise) chk("ready_low_run", 12'(bus.o_ready), 12'd0);
      tick();
      l++;
    end
    if (noise) chk("ready_low_done", 12'(bus.o_ready), 12'd0);
    bus.i_valid = 1'b0;
  endtask
  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_minuend = '0;
    bus.i_subtrahend = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_ready", 12'(bus.o_ready), 12'd1);
    chk("rst_valid", 12'(bus.o_valid), 12'd0);
    chk("rst_diff", bus.o_diff, 12'h000);
    chk("rst_borrow", 12'(bus.o_borrow), 12'd0);
    chk("rst_mask", 12'(bus.o_skip_mask), 12'd0);
    for (int i = 0; i < 10; i++) begin
      op(va[i], vb[i], i == 2, lat);
      chk($sformatf("lat_%0d", i), 12'(lat), 12'd4);
      chk($sformatf("diff_%0d", i), bus.o_diff, vd[i]);
      chk($sformatf("borrow_%0d", i), 12'(bus.o_borrow), 12'(vbo[i]));
      chk($sformatf("mask_%0d", i), 12'(bus.o_skip_mask), 12'(vm[i]));
      tick();
      chk($sformatf("valid_drop_%0d", i), 12'(bus.o_valid), 12'd0);
    end
    bus.i_ready = 1'b0;
    op(12'h5A5, 12'h0F0, 1'b0, lat);
    chk("bp_lat", 12'(lat), 12'd4);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 12'(bus.o_valid), 12'd1);
      chk("bp_diff", bus.o_diff, 12'h4B5);
      chk("bp_borrow", 12'(bus.o_borrow), 12'd0);
      chk("bp_mask", 12'(bus.o_skip_mask), 12'd0);
      chk("bp_ready", 12'(bus.o_ready), 12'd0);
    end
    bus.i_ready = 1'b1;
    tick();
    chk("bp_release_valid", 12'(bus.o_valid), 12'd0);
    chk("bp_release_ready", 12'(bus.o_ready), 12'd1);
    bus.i_minuend = 12'h3C7;
    bus.i_subtrahend = 12'h2C7;
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", 12'(bus.o_valid), 12'd0);
    chk("abort_diff", bus.o_diff, 12'h000);
    chk("abort_ready", 12'(bus.o_ready), 12'd1);
    chk("abort_borrow", 12'(bus.o_borrow), 12'd0);
    chk("abort_mask", 12'(bus.o_skip_mask), 12'd0);
    op(12'h0F0, 12'h5A5, 1'b0, lat);
    chk("post_abort_lat", 12'(lat), 12'd4);
    chk("post_abort_diff", bus.o_diff, 12'hB4B);
    chk("post_abort_borrow", 12'(bus.o_borrow), 12'd1);
    chk("post_abort_mask", 12'(bus.o_skip_mask), 12'd0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
